// File: rtl/pipeline_stall_controller.sv
// -----------------------------------------------------------------------------
// pipeline_stall_controller
//
// Central stall/flush sequencer for the 5-stage RV32IM pipeline. It arbitrates
// between data-memory wait, multi-cycle mul/div, taken branch/jump redirects
// and load-use hazards, and drives the write-enable and bubble/flush controls
// for the PC and every pipeline register. It also keeps a saturating count of
// cycles in which the PC was held, for performance checks.
//
// Request priority, highest first:
//   DMEM_BUSY > mul/div (start or wait) > branch redirect / flush > load-use
//
// Parameters:
//   FLUSH_CYCLES     cycles IF/ID is flushed and ID/EX bubbled per redirect (1..7)
//   MULDIV_TIMEOUT   stalled MULDIV_WAIT cycles before MULDIV_ERR is raised
//   STALL_CNT_WIDTH  width of STALL_COUNT
//
// Ports:
//   CLK              pipeline clock, all state changes on the rising edge
//   RESET            synchronous, active-high reset
//   LU_HAZARD        load in EX, dependent instruction in ID
//   BRANCH_TAKEN_EX  taken branch/jump resolved in EX (PC redirect this cycle)
//   MULDIV_START_EX  multi-cycle M-extension op entered EX this cycle
//   MULDIV_DONE      mul/div result valid this cycle
//   DMEM_BUSY        data memory not ready, freeze the whole pipeline
//   PC_WRITE_EN      PC update enable
//   IF_ID_WRITE_EN   IF/ID load enable       IF_ID_FLUSH    clear IF/ID to NOP
//   ID_EX_WRITE_EN   ID/EX load enable       ID_EX_BUBBLE   load NOP into ID/EX
//   EX_MEM_WRITE_EN  EX/MEM load enable      EX_MEM_BUBBLE  load NOP into EX/MEM
//   MEM_WB_WRITE_EN  MEM/WB load enable
//   MULDIV_ERR       sticky mul/div timeout flag, cleared only by RESET
//   STALL_COUNT      saturating count of cycles with PC_WRITE_EN=0
//   STATE            current FSM state (debug): 0 RUN, 1 MULDIV_WAIT, 2 FLUSH
// -----------------------------------------------------------------------------
module pipeline_stall_controller #(
  parameter int FLUSH_CYCLES    = 1,
  parameter int MULDIV_TIMEOUT  = 40,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       LU_HAZARD,
  input  logic                       BRANCH_TAKEN_EX,
  input  logic                       MULDIV_START_EX,
  input  logic                       MULDIV_DONE,
  input  logic                       DMEM_BUSY,
  output logic                       PC_WRITE_EN,
  output logic                       IF_ID_WRITE_EN,
  output logic                       IF_ID_FLUSH,
  output logic                       ID_EX_WRITE_EN,
  output logic                       ID_EX_BUBBLE,
  output logic                       EX_MEM_WRITE_EN,
  output logic                       EX_MEM_BUBBLE,
  output logic                       MEM_WB_WRITE_EN,
  output logic                       MULDIV_ERR,
  output logic [STALL_CNT_WIDTH-1:0] STALL_COUNT,
  output logic [1:0]                 STATE
);

  // Timeout counter only has to reach MULDIV_TIMEOUT-1 before it fires.
  localparam int TO_W = (MULDIV_TIMEOUT > 1) ? $clog2(MULDIV_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST     = TO_W'(MULDIV_TIMEOUT - 1);
  localparam logic [2:0]      FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN         = 2'd0,
    ST_MULDIV_WAIT = 2'd1,
    ST_FLUSH       = 2'd2
  } state_e;

  // What the pipeline controls should do this cycle; decoded into the
  // individual enables below.
  typedef enum logic [2:0] {
    ACT_NONE,
    ACT_FREEZE,
    ACT_MULDIV_STALL,
    ACT_FLUSH,
    ACT_LOAD_USE
  } action_e;

  state_e          state;
  logic [2:0]      flush_cnt;
  logic [TO_W-1:0] to_cnt;
  action_e         action;

  // ---------------------------------------------------------------------------
  // Action selection: priority arbitration of the current state and requests.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path through
    // the if/case can leave it unassigned and infer a latch.
    action = ACT_NONE;
    if (RESET) begin
      action = ACT_NONE;
    end else if (DMEM_BUSY) begin
      action = ACT_FREEZE;
    end else begin
      case (state)
        ST_RUN: begin
          // A mul/div start cycle keeps default controls so the op latches
          // into the EX unit; the stall begins next cycle.
          if (MULDIV_START_EX)      action = ACT_NONE;
          else if (BRANCH_TAKEN_EX) action = ACT_FLUSH;  // squashes the load-use victim
          else if (LU_HAZARD)       action = ACT_LOAD_USE;
        end
        ST_MULDIV_WAIT: begin
          // The done cycle runs with defaults so the result lands in EX/MEM.
          if (!MULDIV_DONE) action = ACT_MULDIV_STALL;
        end
        ST_FLUSH: begin
          if (!MULDIV_START_EX) action = ACT_FLUSH;
        end
        default: action = ACT_NONE;  // illegal encoding, recovers next edge
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    PC_WRITE_EN     = 1'b1;
    IF_ID_WRITE_EN  = 1'b1;
    IF_ID_FLUSH     = 1'b0;
    ID_EX_WRITE_EN  = 1'b1;
    ID_EX_BUBBLE    = 1'b0;
    EX_MEM_WRITE_EN = 1'b1;
    EX_MEM_BUBBLE   = 1'b0;
    MEM_WB_WRITE_EN = 1'b1;
    unique case (action)
      ACT_FREEZE: begin
        PC_WRITE_EN     = 1'b0;
        IF_ID_WRITE_EN  = 1'b0;
        ID_EX_WRITE_EN  = 1'b0;
        EX_MEM_WRITE_EN = 1'b0;
        MEM_WB_WRITE_EN = 1'b0;
      end
      ACT_MULDIV_STALL: begin
        // Hold the front end and the op in EX; push NOPs into EX/MEM while
        // MEM/WB keeps draining the older instructions.
        PC_WRITE_EN    = 1'b0;
        IF_ID_WRITE_EN = 1'b0;
        ID_EX_WRITE_EN = 1'b0;
        EX_MEM_BUBBLE  = 1'b1;
      end
      ACT_FLUSH: begin
        // PC stays enabled so the redirect target is loaded.
        IF_ID_FLUSH  = 1'b1;
        ID_EX_BUBBLE = 1'b1;
      end
      ACT_LOAD_USE: begin
        PC_WRITE_EN    = 1'b0;
        IF_ID_WRITE_EN = 1'b0;
        ID_EX_BUBBLE   = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, counters and sticky error
  // ---------------------------------------------------------------------------
  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_RUN;
      flush_cnt   <= '0;
      to_cnt      <= '0;
      STALL_COUNT <= '0;
      MULDIV_ERR  <= 1'b0;
    end else begin
      if (!PC_WRITE_EN && (STALL_COUNT != '1)) begin
        STALL_COUNT <= STALL_COUNT + 1'b1;
      end

      if (!(state inside {ST_RUN, ST_MULDIV_WAIT, ST_FLUSH})) begin
        // Illegal encoding always recovers, even under a memory freeze.
        state     <= ST_RUN;
        flush_cnt <= '0;
        to_cnt    <= '0;
      end else if (!DMEM_BUSY) begin
        case (state)
          ST_RUN: begin
            if (MULDIV_START_EX) begin
              state  <= ST_MULDIV_WAIT;
              to_cnt <= '0;
            end else if (BRANCH_TAKEN_EX && (FLUSH_CYCLES > 1)) begin
              // The redirect cycle itself is the first flush cycle.
              state     <= ST_FLUSH;
              flush_cnt <= FLUSH_RELOAD;
            end
          end

          ST_MULDIV_WAIT: begin
            if (MULDIV_DONE) begin
              state  <= ST_RUN;
              to_cnt <= '0;
            end else if (to_cnt == TO_LAST) begin
              state      <= ST_RUN;
              to_cnt     <= '0;
              MULDIV_ERR <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end

          ST_FLUSH: begin
            if (MULDIV_START_EX) begin
              state     <= ST_MULDIV_WAIT;
              flush_cnt <= '0;
              to_cnt    <= '0;
            end else if (BRANCH_TAKEN_EX) begin
              flush_cnt <= FLUSH_RELOAD;
            end else if (flush_cnt <= 3'd1) begin
              state     <= ST_RUN;
              flush_cnt <= '0;
            end else begin
              flush_cnt <= flush_cnt - 1'b1;
            end
          end

          default: state <= ST_RUN;
        endcase
      end
    end
  end

  assign STATE = state;

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage RV32IM pipeline.
- Sits directly downstream of the hazard detection unit and consumes its load-use hazard flag. Also takes branch-redirect, multi-cycle mul/div and memory-wait requests.
- Drives write-enable and bubble/flush controls for the PC and all pipeline registers, and keeps a saturating stall-cycle counter for performance checks.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive cycles IF/ID is flushed and ID/EX bubbled after a taken branch/jump (1..7).
- MULDIV_TIMEOUT, 40, cycles spent in MULDIV_WAIT without MULDIV_DONE before MULDIV_ERR is raised.
- STALL_CNT_WIDTH, 16, width of STALL_COUNT.

Ports:
- CLK  input  1  pipeline clock; all state changes on rising edge.
- RESET  input  1  synchronous, active-high reset.
- LU_HAZARD  input  1  load-use hazard from the hazard detection unit (load in EX, dependent instruction in ID).
- BRANCH_TAKEN_EX  input  1  taken branch/jump resolved in EX; redirect PC this cycle.
- MULDIV_START_EX  input  1  multi-cycle M-extension op entered EX this cycle.
- MULDIV_DONE  input  1  mul/div result valid this cycle.
- DMEM_BUSY  input  1  data memory not ready; whole pipeline must freeze.
- PC_WRITE_EN  output  1  PC update enable.
- IF_ID_WRITE_EN  output  1  IF/ID register load enable.
- IF_ID_FLUSH  output  1  clear IF/ID to NOP.
- ID_EX_WRITE_EN  output  1  ID/EX register load enable.
- ID_EX_BUBBLE  output  1  load NOP into ID/EX.
- EX_MEM_WRITE_EN  output  1  EX/MEM register load enable.
- EX_MEM_BUBBLE  output  1  load NOP into EX/MEM.
- MEM_WB_WRITE_EN  output  1  MEM/WB register load enable.
- MULDIV_ERR  output  1  sticky timeout flag.
- STALL_COUNT  output  STALL_CNT_WIDTH  saturating count of cycles with PC_WRITE_EN=0.
- STATE  output  2  current FSM state (debug).

Behaviour:
- States: RUN=0, MULDIV_WAIT=1, FLUSH=2. Code 3 is illegal and recovers to RUN on the next edge.
- Outputs are combinational from the current state and current inputs. State and counters are registered.
- RESET high at an edge: STATE=RUN, flush counter=0, timeout counter=0, STALL_COUNT=0, MULDIV_ERR=0. Reset mid-MULDIV_WAIT or mid-FLUSH aborts it.
- Outputs while RESET is high: all *_WRITE_EN=1, all bubble/flush=0.
- Default (RUN, no requests): all *_WRITE_EN=1, all bubble/flush=0.
- Priority, highest first: DMEM_BUSY > MULDIV_WAIT state / MULDIV_START_EX > BRANCH_TAKEN_EX / FLUSH state > LU_HAZARD.
- DMEM_BUSY=1, any state:
  - All *_WRITE_EN=0, all bubble/flush=0.
  - State and flush/timeout counters hold.
  - STALL_COUNT increments.
- LU_HAZARD in RUN, no higher request:
  - PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1; others default.
  - Exactly one bubble per assertion cycle; no state change.
- BRANCH_TAKEN_EX in RUN:
  - PC_WRITE_EN=1 (redirect), IF_ID_FLUSH=1, ID_EX_BUBBLE=1; LU_HAZARD ignored (dependent instruction is squashed).
  - If FLUSH_CYCLES>1: go to FLUSH with count=FLUSH_CYCLES-1.
- In FLUSH: same flush outputs each cycle, count decrements, return to RUN when count reaches 0.
  - A new BRANCH_TAKEN_EX in FLUSH reloads count=FLUSH_CYCLES-1.
- MULDIV_START_EX in RUN or FLUSH: enter MULDIV_WAIT next edge; the start cycle itself has default outputs (op latches into EX unit).
- In MULDIV_WAIT while MULDIV_DONE=0:
  - PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_WRITE_EN=0, EX_MEM_BUBBLE=1; MEM_WB_WRITE_EN=1 so older instructions drain.
  - Timeout counter increments.
- MULDIV_DONE=1 in MULDIV_WAIT: outputs default that cycle (result captured into EX/MEM); return to RUN; timeout counter cleared.
- Timeout counter reaching MULDIV_TIMEOUT: MULDIV_ERR=1 (sticky until RESET), return to RUN.
- MULDIV_DONE outside MULDIV_WAIT is ignored.
- STALL_COUNT saturates at all-ones; it does not wrap.

Test Plan:
- RESET 2 cycles, then idle 5 cycles -> all WRITE_EN=1, bubbles 0, STATE=0, STALL_COUNT=0.
- LU_HAZARD=1 for one cycle -> that cycle PC_WRITE_EN=0, IF_ID_WRITE_EN=0, ID_EX_BUBBLE=1; next cycle defaults; STALL_COUNT=1.
- LU_HAZARD=1 and BRANCH_TAKEN_EX=1 same cycle, FLUSH_CYCLES=2 -> PC_WRITE_EN=1, IF_ID_FLUSH=1, ID_EX_BUBBLE=1 for 2 cycles, STATE 2 then 0.
- MULDIV_START_EX pulse, MULDIV_DONE after 33 cycles -> 33 cycles STATE=1, EX_MEM_BUBBLE=1, PC frozen; done cycle defaults; STALL_COUNT=33; MULDIV_ERR=0.
- DMEM_BUSY=1 for 3 cycles during MULDIV_WAIT, MULDIV_TIMEOUT=8 -> all enables 0 and timeout frozen for those cycles; ERR fires only after 8 non-busy wait cycles.
- RESET asserted mid-MULDIV_WAIT; separately, force STALL_COUNT near max with STALL_CNT_WIDTH=4 -> state returns to RUN with ERR=0; counter holds at 15 instead of wrapping.
